// File: rtl/fir_i2s_tx.sv
// fir_i2s_tx: FIFO-buffered mono-to-stereo I2S transmitter with an NCO bit clock.
// Optional saturating drop/underrun counters when I2S_TX_STATS_EN is defined.
module fir_i2s_tx #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          PRIME_LEVEL = 4,
  parameter logic [31:0] PHASE_INC   = 32'd263882791
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  input  logic                          en,
  input  logic                          clr_flags,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          active
`ifdef I2S_TX_STATS_EN
  ,
  output logic [15:0]                   overflow_cnt,
  output logic [15:0]                   underflow_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);
  localparam logic [5:0]    DW6     = 6'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] hold;
  logic [31:0]           acc;
  logic [5:0]            bit_cnt;

  logic [32:0] acc_sum;
  logic [5:0]  nxt_bit;
  logic [31:0] slot;
  logic        tick;
  logic        fall;
  logic        full;
  logic        empty;
  logic        run_now;
  logic        pop_slot;
  logic        do_pop;
  logic        do_wr;
  logic        ovf_set;
  logic        udf_set;
  logic        lr_nxt;
  logic        sd_nxt;

  always_comb begin
    acc_sum  = {1'b0, acc} + {1'b0, PHASE_INC};
    tick     = acc_sum[32] && (state != IDLE);
    fall     = tick && i2s_bclk;
    nxt_bit  = bit_cnt + 6'd1;
    full     = (fifo_level == DEPTH_L);
    empty    = (fifo_level == '0);
    run_now  = (state == RUN) || ((state == STOP) && en);
    pop_slot = fall && (nxt_bit == 6'd63) && run_now;
    do_pop   = pop_slot && !empty;
    do_wr    = s_valid && !full;
    ovf_set  = s_valid && full;
    udf_set  = pop_slot && empty;
    // left-justified 32-bit slot, reused for both channels
    slot     = 32'(hold) << (32 - DATA_WIDTH);
    lr_nxt   = (nxt_bit >= 6'd31) && (nxt_bit <= 6'd62);
    sd_nxt   = ({1'b0, nxt_bit[4:0]} < DW6) && slot[~nxt_bit[4:0]];
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      hold       <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        hold   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end else if (udf_set) begin
        hold <= '0;
      end
      unique case ({do_wr, do_pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (ovf_set)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (udf_set)        underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;
    end
  end

`ifdef I2S_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_cnt  <= '0;
      underflow_cnt <= '0;
    end else begin
      if (ovf_set) begin
        if (overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
      end else if (clr_flags) begin
        overflow_cnt <= '0;
      end
      if (udf_set) begin
        if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      end else if (clr_flags) begin
        underflow_cnt <= '0;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      active    <= 1'b0;
      acc       <= '0;
      bit_cnt   <= 6'd62;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          acc       <= '0;
          bit_cnt   <= 6'd62;
          i2s_bclk  <= 1'b0;
          i2s_lrclk <= 1'b0;
          i2s_sdata <= 1'b0;
          if (en && (fifo_level >= PRIME_L)) begin
            state  <= RUN;
            active <= 1'b1;
          end
        end
        RUN, STOP: begin
          acc <= acc_sum[31:0];
          if (tick) i2s_bclk <= !i2s_bclk;
          if (fall) begin
            bit_cnt   <= nxt_bit;
            i2s_lrclk <= lr_nxt;
            i2s_sdata <= sd_nxt;
          end
          if (state == RUN) begin
            if (!en) state <= STOP;
          end else if (en) begin
            state <= RUN;
          end else if (fall && (nxt_bit == 6'd63)) begin
            // frame finished while stopping: park with bclk low
            state   <= IDLE;
            active  <= 1'b0;
            acc     <= '0;
            bit_cnt <= 6'd62;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fir_i2s_tx.md
Name: fir_i2s_tx

Overview:
- Output-side sink for the FIR stream: accepts filtered samples from fir_top (y_out qualified by a one-cycle y_valid) and buffers them in a small FIFO.
- Drains samples at a fixed 48 kHz frame rate as standard I2S (Philips) stereo to an external DAC. The mono sample is duplicated to left and right.
- Sits between fir_top and the board audio pins (Arty S7 PMOD DAC). All logic runs on the 100 MHz system clock.
- Bit clock comes from a phase-accumulator NCO, so no clock divider or second clock domain is needed.

Parameters:
- DATA_WIDTH, 16, sample width; two's complement.
- FIFO_DEPTH, 8, sample FIFO entries; power of 2, at least 4.
- PRIME_LEVEL, 4, FIFO occupancy required before transmission starts; 1 to FIFO_DEPTH.
- PHASE_INC, 263882791, 32-bit NCO increment; round(2^32 * 2*3.072 MHz / 100 MHz). Gives 64 BCLK per 48 kHz frame.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_WIDTH  filtered sample (fir_top y_out).
- s_valid  in  1  one-cycle strobe; s_data is valid (fir_top y_valid).
- en  in  1  transmit enable.
- clr_flags  in  1  clears sticky status flags.
- i2s_bclk  out  1  I2S bit clock, nominally 3.072 MHz.
- i2s_lrclk  out  1  word select; 0 = left.
- i2s_sdata  out  1  serial data, MSB first.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- underflow  out  1  sticky: a frame was sent with no sample available.
- active  out  1  high in RUN and STOP states.

Behaviour:
- Reset: all outputs 0; FIFO empty; NCO accumulator 0; state IDLE; bit_cnt = 62.
- FIFO write:
  - s_valid with FIFO not full → write; fifo_level rises by 1 on the next cycle.
  - s_valid with FIFO full → sample dropped, overflow set next cycle.
  - Writes are accepted in every state.
- NCO:
  - Each cycle acc <= acc + PHASE_INC (mod 2^32); carry-out = tick.
  - In RUN/STOP, each tick toggles i2s_bclk.
  - In IDLE, i2s_bclk is held 0 and the accumulator is held at 0.
- Falling tick (bclk 1→0):
  - bit_cnt increments mod 64.
  - i2s_lrclk and i2s_sdata update in the same cycle as the bclk fall.
  - The DAC samples on the bclk rising edge.
- Frame map, by bit_cnt:
  - i2s_lrclk = 1 for bit_cnt 31..62, else 0. This gives the I2S one-bit delay.
  - bit_cnt 0..15: sdata = hold[15-bit_cnt] (left).
  - bit_cnt 32..47: sdata = hold[47-bit_cnt] (right).
  - All other bits: 0.
  - For DATA_WIDTH < 32 the sample is left-justified in a 32-bit slot.
- Pop: on the falling tick entering bit_cnt 63 in RUN:
  - FIFO not empty → hold <= FIFO head and the entry is popped.
  - FIFO empty → hold <= 0 and underflow is set.
- Pop and write in the same cycle: both take effect; fifo_level is unchanged; full and empty flags are evaluated before the update.
- State machine:
  - IDLE → RUN when en=1 and fifo_level >= PRIME_LEVEL. Outputs stay quiet until the first falling tick, which enters bit 63 and pops.
  - RUN → STOP when en=0.
  - STOP → IDLE at the falling tick entering bit_cnt 63, with no pop. Bit_cnt is then held at 62.
  - STOP → RUN if en=1 before then.
- Sticky flags: clr_flags clears them. If clr_flags and a set event occur in the same cycle, set wins.
- Timing: average frame = 128 ticks ≈ 2083.33 clk cycles. A 48007 Hz source therefore slowly fills the FIFO; overflow flags the drift.
- Reset mid-frame: outputs go to 0 immediately on the next edge and FIFO contents are discarded.

Optional Feature:
- Macro: I2S_TX_STATS_EN.
- When defined, adds output ports overflow_cnt [15:0] and underflow_cnt [15:0]:
  - Saturating counts of dropped samples and zero-filled frames.
  - Cleared by rst and clr_flags.
  - Increment in the same cycle the sticky flag sets.
- When undefined, these ports and counters do not exist; the sticky flags are unchanged.

Test Plan:
- PHASE_INC = 2^28 (tick every 16 cycles), PRIME_LEVEL = 4. Write 0x8001, 0x1234, 0x7FFF, 0x0000, en=1 → RUN. Frame 1 sends 0x8001 MSB-first on bits 0..15 and again on 32..47, with zeros on the other bits. Frames 2 and 3 send 0x1234 and 0x7FFF. lrclk is high exactly on bit_cnt 31..62; the bclk period is 32 clk cycles.
- Fill 8 samples with en=0, then strobe s_valid with 0xAAAA → overflow=1, fifo_level stays 8, and 0xAAAA is never transmitted. Assert clr_flags → overflow=0.
- Prime 4 samples, run 5 frames with no further writes → frame 5 is all zeros and underflow=1. With I2S_TX_STATS_EN, underflow_cnt=1.
- Deassert en mid-frame → the current frame completes, bclk stops low after the bit_cnt 63 fall, active=0, and fifo_level is unchanged by the stop.
- Assert rst at bit_cnt 20 → next cycle all outputs are 0, fifo_level=0, state IDLE.
- Default PHASE_INC, 48007 Hz source → over 10 s simulated, frame count is 480000±1. overflow asserts once the accumulated drift exceeds FIFO_DEPTH-PRIME_LEVEL samples.
